// File: rtl/bist_fail_logger.sv
// BIST fail-report logger: captures miscompares into a small FIFO, counts them and tracks overflow.
// Optional accumulated failing-bit map enabled by defining BIST_FAIL_BITMAP_EN.
//
// state  | meaning
// IDLE   | waiting for a BIST run to start
// LOG    | run in progress, miscompares are captured
// DONE   | run finished, log may still be drained, pass is valid
module bist_fail_logger #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              test_active,
    input  logic              test_done,
    input  logic              fail_vld,
    input  logic [ADDR_W-1:0] fail_addr,
    input  logic [DATA_W-1:0] fail_exp,
    input  logic [DATA_W-1:0] fail_act,
    input  logic [2:0]        fail_phase,
    output logic              rd_vld,
    input  logic              rd_rdy,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_exp,
    output logic [DATA_W-1:0] rd_act,
    output logic [2:0]        rd_phase,
    output logic [DATA_W-1:0] rd_syn,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              overflow,
    output logic [1:0]        state_o,
    output logic              pass,
    output logic [DATA_W-1:0] fail_bits
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOG  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   run_start, capture, log_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state_q <= S_IDLE;
        else if (clr) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (test_active) state_d = S_LOG;
            S_LOG:   if (test_done || !test_active) state_d = S_DONE;
            S_DONE:  if (test_active) state_d = S_LOG;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run_start = 1'b0;
        capture   = 1'b0;
        log_end   = 1'b0;
        state_o   = state_q;
        case (state_q)
            S_IDLE: run_start = test_active;
            S_LOG: begin
                capture = fail_vld;
                log_end = test_done || !test_active;
            end
            S_DONE: run_start = test_active;
            default: ;
        endcase
    end

    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic [DATA_W-1:0] mem_exp   [DEPTH];
    logic [DATA_W-1:0] mem_act   [DEPTH];
    logic [2:0]        mem_phase [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             overflow_q, overflow_d, pass_q, pass_d;
    logic             empty, full, pop, push;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign pop    = !empty && rd_rdy;
    // A full FIFO still accepts a capture when the head leaves on the same edge.
    assign push   = capture && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fail_cnt_d = fail_cnt_q;
        overflow_d = overflow_q;
        pass_d     = 1'b0;
        if (run_start) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fail_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (capture && !(&fail_cnt_q)) fail_cnt_d = fail_cnt_q + CNT_W'(1);
            if (capture && full && !pop) overflow_d = 1'b1;
            if (log_end)
                pass_d = (fail_cnt_q == '0) && !capture;
            else if (state_q == S_DONE)
                pass_d = pass_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fail_cnt_q <= '0;
            overflow_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fail_cnt_q <= fail_cnt_d;
            overflow_q <= overflow_d;
            pass_q     <= pass_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_idx]  <= fail_addr;
            mem_exp[wr_idx]   <= fail_exp;
            mem_act[wr_idx]   <= fail_act;
            mem_phase[wr_idx] <= fail_phase;
        end
    end

    assign rd_vld   = !empty;
    assign rd_addr  = empty ? '0 : mem_addr[rd_idx];
    assign rd_exp   = empty ? '0 : mem_exp[rd_idx];
    assign rd_act   = empty ? '0 : mem_act[rd_idx];
    assign rd_phase = empty ? '0 : mem_phase[rd_idx];
    assign rd_syn   = rd_exp ^ rd_act;
    assign fail_cnt = fail_cnt_q;
    assign overflow = overflow_q;
    assign pass     = pass_q;

`ifdef BIST_FAIL_BITMAP_EN
    logic [DATA_W-1:0] fail_bits_q;

    // Dropped captures still contribute, so stuck bits show even on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   fail_bits_q <= '0;
        else if (clr || run_start) fail_bits_q <= '0;
        else if (capture)          fail_bits_q <= fail_bits_q | (fail_exp ^ fail_act);
    end

    assign fail_bits = fail_bits_q;
`else
    assign fail_bits = '0;
`endif

endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed bench for bist_fail_logger; counter narrowed to 4 bits to reach saturation quickly.
// Expects fail_bits accumulation when BIST_FAIL_BITMAP_EN is defined, zero otherwise.
module tb_bist_fail_logger;

    logic       clk, rst, clr, test_active, test_done, fail_vld, rd_rdy;
    logic [7:0] fail_addr, fail_exp, fail_act;
    logic [2:0] fail_phase;
    logic       rd_vld, overflow, pass;
    logic [7:0] rd_addr, rd_exp, rd_act, rd_syn, fail_bits;
    logic [2:0] rd_phase;
    logic [3:0] fail_cnt;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    bist_fail_logger #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .test_active(test_active), .test_done(test_done),
        .fail_vld(fail_vld), .fail_addr(fail_addr), .fail_exp(fail_exp),
        .fail_act(fail_act), .fail_phase(fail_phase),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_addr(rd_addr), .rd_exp(rd_exp),
        .rd_act(rd_act), .rd_phase(rd_phase), .rd_syn(rd_syn),
        .fail_cnt(fail_cnt), .overflow(overflow), .state_o(state_o),
        .pass(pass), .fail_bits(fail_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cap(input logic [7:0] a, input logic [7:0] e, input logic [7:0] x,
                           input logic [2:0] ph);
        fail_vld   = 1'b1;
        fail_addr  = a;
        fail_exp   = e;
        fail_act   = x;
        fail_phase = ph;
    endtask

    task automatic no_cap();
        fail_vld = 1'b0; fail_addr = '0; fail_exp = '0; fail_act = '0; fail_phase = '0;
    endtask

    logic [7:0] exp_drain [4];

    initial begin
        rst = 1'b1; clr = 1'b0; test_active = 1'b0; test_done = 1'b0; rd_rdy = 1'b0;
        no_cap();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state", state_o, 2'b00);
        check_eq("rst_rd_vld", rd_vld, 0);
        check_eq("rst_cnt", fail_cnt, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_ovf", overflow, 0);
        rst = 1'b0;

        // Clean run: no failures, pass expected
        test_active = 1'b1;
        step();
        check_eq("idle_to_log", state_o, 2'b01);
        repeat (20) step();
        test_done = 1'b1; test_active = 1'b0;
        step();
        test_done = 1'b0;
        check_eq("clean_state", state_o, 2'b10);
        check_eq("clean_pass", pass, 1);
        check_eq("clean_cnt", fail_cnt, 0);
        check_eq("clean_rd_vld", rd_vld, 0);
        step();
        check_eq("done_hold", state_o, 2'b10);

        // Single capture with syndrome 01
        test_active = 1'b1;
        step();
        check_eq("rerun_state", state_o, 2'b01);
        check_eq("rerun_pass", pass, 0);
        set_cap(8'h3C, 8'hAA, 8'hAB, 3'b000);
        step();
        no_cap();
        check_eq("single_vld", rd_vld, 1);
        check_eq("single_addr", rd_addr, 8'h3C);
        check_eq("single_exp", rd_exp, 8'hAA);
        check_eq("single_act", rd_act, 8'hAB);
        check_eq("single_syn", rd_syn, 8'h01);
        check_eq("single_cnt", fail_cnt, 1);
        step();
        check_eq("hold_addr", rd_addr, 8'h3C);
        check_eq("hold_vld", rd_vld, 1);
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        check_eq("pop_vld", rd_vld, 0);
        check_eq("pop_addr_zero", rd_addr, 0);

        // Six captures into a 4-deep FIFO without reads
        for (int i = 0; i < 6; i++) begin
            set_cap(8'(i), 8'h00, 8'h80, 3'(i));
            step();
        end
        no_cap();
        check_eq("ovf_cnt", fail_cnt, 7);
        check_eq("ovf_flag", overflow, 1);
`ifdef BIST_FAIL_BITMAP_EN
        check_eq("bitmap", fail_bits, 8'h81);
`else
        check_eq("bitmap_off", fail_bits, 8'h00);
`endif
        for (int i = 0; i < 4; i++) begin
            check_eq("drain6_vld", rd_vld, 1);
            check_eq("drain6_addr", rd_addr, i);
            check_eq("drain6_phase", rd_phase, i);
            rd_rdy = 1'b1;
            step();
        end
        rd_rdy = 1'b0;
        check_eq("drain6_empty", rd_vld, 0);

        // End run with failures, then restart
        test_active = 1'b0;
        step();
        check_eq("fail_done_state", state_o, 2'b10);
        check_eq("fail_done_pass", pass, 0);
        test_active = 1'b1;
        step();
        check_eq("restart_cnt", fail_cnt, 0);
        check_eq("restart_ovf", overflow, 0);
        check_eq("restart_bits", fail_bits, 0);

        // Full FIFO with simultaneous pop accepts the push
        for (int i = 0; i < 4; i++) begin
            set_cap(8'(i), 8'h11, 8'h10, 3'b010);
            step();
        end
        set_cap(8'h09, 8'h11, 8'h10, 3'b010);
        rd_rdy = 1'b1;
        step();
        no_cap();
        rd_rdy = 1'b0;
        check_eq("fullpop_ovf", overflow, 0);
        check_eq("fullpop_cnt", fail_cnt, 5);
        exp_drain[0] = 8'h01; exp_drain[1] = 8'h02; exp_drain[2] = 8'h03; exp_drain[3] = 8'h09;
        for (int i = 0; i < 4; i++) begin
            check_eq("fullpop_addr", rd_addr, exp_drain[i]);
            rd_rdy = 1'b1;
            step();
        end
        rd_rdy = 1'b0;
        check_eq("fullpop_empty", rd_vld, 0);

        // Counter saturates at all-ones while continuously draining
        rd_rdy = 1'b1;
        for (int i = 0; i < 18; i++) begin
            set_cap(8'h40 + 8'(i), 8'hF0, 8'h0F, 3'b111);
            step();
        end
        no_cap();
        check_eq("sat_cnt", fail_cnt, 4'hF);
        check_eq("sat_ovf", overflow, 0);
        step();
        rd_rdy = 1'b0;
        test_active = 1'b0;
        step();
        check_eq("sat_done_state", state_o, 2'b10);
        check_eq("sat_pass", pass, 0);

        // Capture on the test_done cycle counts and clears pass
        test_active = 1'b1;
        step();
        set_cap(8'h55, 8'h01, 8'h03, 3'b001);
        test_done = 1'b1; test_active = 1'b0;
        step();
        no_cap();
        test_done = 1'b0;
        check_eq("lastcyc_state", state_o, 2'b10);
        check_eq("lastcyc_cnt", fail_cnt, 1);
        check_eq("lastcyc_pass", pass, 0);
        check_eq("lastcyc_addr", rd_addr, 8'h55);
        check_eq("lastcyc_syn", rd_syn, 8'h02);
        set_cap(8'h66, 8'h00, 8'hFF, 3'b000);
        step();
        no_cap();
        check_eq("done_ignore_cnt", fail_cnt, 1);
        check_eq("done_ignore_addr", rd_addr, 8'h55);

        // Restart from DONE discards unread entries
        test_active = 1'b1;
        step();
        check_eq("discard_state", state_o, 2'b01);
        check_eq("discard_vld", rd_vld, 0);
        check_eq("discard_cnt", fail_cnt, 0);

        // Synchronous clear
        set_cap(8'h77, 8'h00, 8'h01, 3'b000);
        step();
        no_cap();
        check_eq("preclr_vld", rd_vld, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("clr_state", state_o, 2'b00);
        check_eq("clr_vld", rd_vld, 0);
        check_eq("clr_cnt", fail_cnt, 0);

        // Asynchronous reset mid-LOG
        step();
        check_eq("relog_state", state_o, 2'b01);
        set_cap(8'h88, 8'h00, 8'h01, 3'b000);
        step();
        no_cap();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_state", state_o, 2'b00);
        check_eq("arst_vld", rd_vld, 0);
        check_eq("arst_addr", rd_addr, 0);
        check_eq("arst_cnt", fail_cnt, 0);
        check_eq("arst_ovf", overflow, 0);
        check_eq("arst_bits", fail_bits, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bist_fail_logger.md
Name: bist_fail_logger

Overview:
- Receiving end of the BIST fail-report path. It consumes per-cycle compare results (address, expected, actual, pattern selector) from the BIST compare stage.
- It records failing entries in a small FIFO, counts all failures and tracks overflow.
- A host or scan-out path drains the log through a valid/ready read port.
- It sits between the BIST comparator/controller and the test-access logic, and provides diagnosis beyond the single-bit fail flag.

Parameters:
- ADDR_W, 8, width of failing address.
- DATA_W, 8, width of expected/actual data words.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the saturating total-fail counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear to IDLE; flushes FIFO, counters and flags.
- test_active  in  1  BIST in test mode (NbarT).
- test_done  in  1  one-cycle pulse: BIST sequence finished (counter carry-out).
- fail_vld  in  1  compare result this cycle is a miscompare.
- fail_addr  in  ADDR_W  address under test.
- fail_exp  in  DATA_W  expected pattern.
- fail_act  in  DATA_W  data read from RAM.
- fail_phase  in  3  pattern selector (counter q[11:9]).
- rd_vld  out  1  FIFO head valid.
- rd_rdy  in  1  consumer accepts head.
- rd_addr  out  ADDR_W  head address.
- rd_exp  out  DATA_W  head expected data.
- rd_act  out  DATA_W  head actual data.
- rd_phase  out  3  head phase.
- rd_syn  out  DATA_W  head syndrome = rd_exp XOR rd_act.
- fail_cnt  out  CNT_W  total miscompares in the current run, saturating.
- overflow  out  1  sticky; at least one failure was dropped because the FIFO was full.
- state_o  out  2  00 IDLE, 01 LOG, 10 DONE.
- pass  out  1  high in DONE when fail_cnt==0.
- fail_bits  out  DATA_W  accumulated failing bit map (optional feature).

Behaviour:
- Reset (rst async, or clr sync) sets all of the following to zero:
  - state IDLE, FIFO empty, rd_vld=0, rd_* outputs 0.
  - fail_cnt=0, overflow=0, pass=0, fail_bits=0.
- State machine:
  - IDLE -> LOG when test_active=1. Entry clears FIFO, fail_cnt, overflow and fail_bits in the same edge.
  - LOG -> DONE on test_done=1 or test_active=0.
  - DONE -> LOG when test_active=1 again. This starts a new run, clears everything and discards unread entries.
  - DONE otherwise holds.
- Capture happens only in LOG with fail_vld=1. A fail_vld in the same cycle as test_done is still captured.
- Capture in any other state is ignored and does not count.
- Push rules:
  - Entry pushed if FIFO not full, or if a pop occurs in the same cycle (full with simultaneous pop accepts the push).
  - If full and no pop: entry dropped, overflow set to 1 (sticky until next run, clr or rst).
- fail_cnt increments on every capture, whether stored or dropped. It saturates at all-ones with no wrap.
- Latency: a captured entry appears on rd_* with rd_vld=1 on the cycle after the capture edge.
- Read handshake:
  - rd_vld = FIFO not empty.
  - Pop on a rising edge with rd_vld&rd_rdy.
  - rd_* hold stable while rd_vld=1 and rd_rdy=0.
  - rd_rdy with an empty FIFO has no effect.
  - Reads are allowed in LOG and DONE.
- Pointers are log2(DEPTH)+1 bits with wrap bit:
  - full when indices are equal and wrap bits differ.
  - empty when both are fully equal.
- rd_* are driven from registered FIFO storage at the read pointer; when empty, rd_* are 0.
- pass is registered: set to 1 on the DONE-entry edge if fail_cnt==0 (including a same-cycle capture), otherwise 0. pass is 0 outside DONE.
- clr has priority over all events. rst has priority over clr.

Optional Feature:
- Macro BIST_FAIL_BITMAP_EN.
- When defined: fail_bits accumulates the OR of (fail_exp XOR fail_act) over every capture in LOG, including dropped entries. It is cleared on run start, clr and rst, and identifies stuck data bits.
- When undefined: fail_bits is tied to 0 and no accumulator register exists.

Test Plan:
- rst, then test_active=1, no fail_vld for 20 cycles, test_done pulse -> state_o=10, pass=1, fail_cnt=0, rd_vld=0.
- LOG, one capture addr=8'h3C, exp=8'hAA, act=8'hAB, phase=3'b000 -> next cycle rd_vld=1, rd_addr=3C, rd_syn=8'h01, fail_cnt=1. Pop with rd_rdy=1 -> rd_vld=0.
- DEPTH=4, six consecutive captures addr 0..5 with rd_rdy=0 -> fail_cnt=6, overflow=1. Drain yields addr 0,1,2,3 in order, then rd_vld=0.
- FIFO full (addrs 0..3), capture addr 9 with rd_rdy=1 in the same cycle -> no overflow. Subsequent drain yields 1,2,3,9.
- In DONE with 2 unread entries, test_active=1 -> FIFO empty, fail_cnt=0, overflow=0, state_o=01. rst asserted mid-LOG -> all outputs 0 immediately.
- BIST_FAIL_BITMAP_EN defined: captures with syndromes 8'h01 and 8'h80 -> fail_bits=8'h81. Macro undefined: fail_bits=0.
